button_bounce_emu: RTL and testbench
====================================

BUTTON_BOUNCE_EMU -- requirements
Module: button_bounce_emu

Interface
REQ-001 Parameter GLITCH_W, default 8: width of the random glitch-length field; each bounce segment lasts 1..2^GLITCH_W cycles.
REQ-002 Parameter SETTLE_CYCLES, default 600000: stable-hold cycles after the final edge, at least 1.
REQ-003 Port CLK, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port RST_N, input, 1: asynchronous, active-low reset.
REQ-005 Port cmd_valid, input, 1: a command is presented.
REQ-006 Port cmd_ready, output, 1: the block can accept a command.
REQ-007 Port cmd_chan, input, 2: target channel, 0..3.
REQ-008 Port cmd_press, input, 1: 1 = press (pin driven low), 0 = release (pin driven high).
REQ-009 Port cmd_bounces, input, 4: number of glitch pairs B, 0..15.
REQ-010 Port PIN, output, 4: emulated active-low button pins; idle/released = 1.
REQ-011 Port busy, output, 1: a command is in progress.
REQ-012 Port done, output, 1: one-cycle pulse when a command completes.

Function
REQ-013 The block SHALL drive bouncy active-low button waveforms on PIN so that the input debouncer can be exercised on hardware and in simulation.
REQ-014 The state machine SHALL have the states IDLE, GLITCH_ON, GLITCH_OFF, SETTLE and DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-016 On accept, the block SHALL latch channel c, target level T = ~cmd_press and B; it goes to GLITCH_ON if B > 0, otherwise to SETTLE.
REQ-017 PIN[c] SHALL change on the same edge that enters a state: T in GLITCH_ON and SETTLE, ~T in GLITCH_OFF.
REQ-018 Every GLITCH_ON or GLITCH_OFF segment SHALL last L = lfsr[GLITCH_W-1:0] + 1 cycles, with L sampled on the entry edge.
REQ-019 The transitions SHALL be:
- GLITCH_ON to GLITCH_OFF at the end of each segment;
- GLITCH_OFF to GLITCH_ON while fewer than B pairs are complete;
- GLITCH_OFF to SETTLE after the B-th pair.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to DONE.
REQ-021 DONE SHALL last one cycle with done = 1, then go to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 PIN bits other than c SHALL hold their last value throughout a command.
REQ-024 Each PIN bit SHALL retain its level after DONE until a later command on that channel or reset.
REQ-025 A command whose T equals the current PIN[c] SHALL execute fully, with glitches to ~T.
REQ-026 cmd inputs SHALL be ignored while cmd_ready = 0; no queuing.
REQ-027 The LFSR SHALL be 16-bit Fibonacci (taps 16,14,13,11), advance every cycle and never hold zero.
REQ-028 The segment counter SHALL count down from L-1.
REQ-029 The settle counter SHALL be sized to hold SETTLE_CYCLES-1 without wrap.

Reset
REQ-030 While RST_N = 0, the block SHALL immediately force, without waiting for CLK:
- PIN = 4'b1111;
- state IDLE;
- busy = 0, done = 0, cmd_ready = 0 (cmd_ready rises only when RST_N = 1);
- lfsr = 16'hACE1;
- all counters 0.
REQ-031 Reset asserted mid-command SHALL abort the command with no done pulse.
REQ-032 cmd_ready SHALL be 1 on the first cycle after RST_N deasserts.

Verification (GLITCH_W=2, SETTLE_CYCLES=10)
REQ-033 Reset release -> PIN=1111, cmd_ready=1, busy=0, done=0.
REQ-034 B=0 press on channel 2, accepted at edge 0:
- PIN=1011 after edge 0;
- done=1 only after edge 10;
- cmd_ready=1 after edge 11;
- no other PIN transitions.
REQ-035 B=3 press on channel 0 -> PIN[0] shows exactly 3 low/high glitch pairs, then stays low for 10 cycles; every segment length is in 1..4; done pulses once.
REQ-036 Release on channel 0 with B=2 after REQ-035 -> PIN[0] goes high, 2 pairs of high/low glitches, then stays 1; PIN[3:1] unchanged.
REQ-037 cmd_valid held high during busy with different fields -> ignored; PIN[cmd_chan] unaffected until the next IDLE accept.
REQ-038 RST_N pulsed low during GLITCH_OFF -> PIN=1111 asynchronously, busy=0, no done pulse; a new command completes normally.

Source files
------------

// File: rtl/button_bounce_emu.sv
// Button bounce emulator: drives B glitch pairs and then a settle hold onto one active-low pin per command.
// PIN changes on the accept edge, and a command takes all its segments plus SETTLE_CYCLES plus one DONE cycle; cmd_ready is high only in IDLE, and commands presented outside IDLE are dropped.
module button_bounce_emu #(
  parameter int GLITCH_W      = 8,
  parameter int SETTLE_CYCLES = 600000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_chan,
  input  logic       cmd_press,
  input  logic [3:0] cmd_bounces,
  output logic [3:0] PIN,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_GLITCH_ON  = 3'd1;
  localparam logic [2:0] S_GLITCH_OFF = 3'd2;
  localparam logic [2:0] S_SETTLE     = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  logic [2:0]          state;
  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic [GLITCH_W-1:0] seg_cnt;
  logic [GLITCH_W-1:0] seg_len;
  logic [SW-1:0]       settle_cnt;
  logic [3:0]          pair_cnt;
  logic [3:0]          pair_next;
  logic [3:0]          bounces;
  logic [1:0]          chan;
  logic                target;

  // Fibonacci taps 16,14,13,11; the nonzero seed keeps it out of the all-zero lock-up state.
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign seg_len   = lfsr[GLITCH_W-1:0];
  assign pair_next = pair_cnt + 4'd1;

  // Gated with RST_N so ready is low for the whole reset, not just after the first edge.
  assign cmd_ready = (state == S_IDLE) && RST_N;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      PIN        <= 4'b1111;
      lfsr       <= 16'hACE1;
      seg_cnt    <= '0;
      settle_cnt <= '0;
      pair_cnt   <= '0;
      bounces    <= '0;
      chan       <= '0;
      target     <= 1'b1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            chan          <= cmd_chan;
            target        <= ~cmd_press;
            bounces       <= cmd_bounces;
            pair_cnt      <= '0;
            PIN[cmd_chan] <= ~cmd_press;
            if (cmd_bounces != 4'd0) begin
              state   <= S_GLITCH_ON;
              seg_cnt <= seg_len;
            end else begin
              state      <= S_SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        S_GLITCH_ON: begin
          if (seg_cnt == '0) begin
            state     <= S_GLITCH_OFF;
            PIN[chan] <= ~target;
            seg_cnt   <= seg_len;
          end else begin
            seg_cnt <= seg_cnt - GLITCH_W'(1);
          end
        end
        S_GLITCH_OFF: begin
          if (seg_cnt == '0) begin
            PIN[chan] <= target;
            if (pair_next == bounces) begin
              state      <= S_SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end else begin
              state    <= S_GLITCH_ON;
              seg_cnt  <= seg_len;
              pair_cnt <= pair_next;
            end
          end else begin
            seg_cnt <= seg_cnt - GLITCH_W'(1);
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_DONE;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_bounce_emu.sv
// Directed bench for button_bounce_emu at GLITCH_W=2, SETTLE_CYCLES=10.
module tb_button_bounce_emu;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_chan = 2'd0;
  logic       cmd_press = 1'b0;
  logic [3:0] cmd_bounces = 4'd0;
  logic [3:0] PIN;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  button_bounce_emu #(.GLITCH_W(2), .SETTLE_CYCLES(10)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_chan   (cmd_chan),
    .cmd_press  (cmd_press),
    .cmd_bounces(cmd_bounces),
    .PIN        (PIN),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called #1 after a rising edge with the block idle. Issues one command, optionally keeps
  // cmd_valid high on channel 3 with other fields while busy, and measures PIN[ch] every cycle.
  task automatic run_cmd(input string tag, input logic [1:0] ch, input logic pr,
                         input logic [3:0] b, input logic spam);
    logic [3:0] pin_before;
    logic [3:0] mask;
    logic       tgt;
    logic       prev;
    int run, trans, bad_seg, other_bad, n_done, done_idx, exit_idx, final_run;
    pin_before = PIN;
    mask       = 4'b0001 << ch;
    tgt        = ~pr;
    run = 1; trans = 0; bad_seg = 0; other_bad = 0; n_done = 0;
    done_idx = -1; exit_idx = -1; final_run = -1;
    check({tag, "_ready_pre"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_chan = ch; cmd_press = pr; cmd_bounces = b;
    @(posedge CLK); #1;
    if (spam) begin
      cmd_chan = 2'd3; cmd_press = 1'b1; cmd_bounces = 4'd5;
    end else begin
      cmd_valid = 1'b0;
    end
    check({tag, "_busy0"}, int'(busy), 1);
    check({tag, "_pin_edge0"}, int'(PIN[ch]), int'(tgt));
    prev = PIN[ch];
    for (int k = 1; k <= 600; k++) begin
      @(posedge CLK); #1;
      if (done) begin
        n_done++;
        if (done_idx < 0) begin
          done_idx  = k;
          final_run = run;
        end
      end
      if ((PIN & ~mask) !== (pin_before & ~mask)) other_bad++;
      if (PIN[ch] !== prev) begin
        trans++;
        if (run > 4) bad_seg++;
        run  = 1;
        prev = PIN[ch];
      end else begin
        run++;
      end
      if (!busy) begin
        exit_idx = k;
        break;
      end
    end
    cmd_valid = 1'b0;
    check({tag, "_transitions"}, trans, 2 * int'(b));
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_settle_len"}, final_run, 10);
    check({tag, "_seg_range"}, bad_seg, 0);
    check({tag, "_other_pins"}, other_bad, 0);
    check({tag, "_final_level"}, int'(PIN[ch]), int'(tgt));
    check({tag, "_idle_after_done"}, exit_idx, done_idx + 1);
    check({tag, "_ready_post"}, int'(cmd_ready), 1);
    if (b == 4'd0) check({tag, "_done_edge"}, done_idx, 10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic hit;
    #12;
    check("rst_pin", int'(PIN), 4'hF);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rel_ready", int'(cmd_ready), 1);
    check("rel_pin", int'(PIN), 4'hF);
    check("rel_busy", int'(busy), 0);
    check("rel_done", int'(done), 0);
    @(posedge CLK); #1;

    run_cmd("b0_ch2_press", 2'd2, 1'b1, 4'd0, 1'b0);
    check("b0_pin", int'(PIN), 4'b1011);

    run_cmd("b3_ch0_press", 2'd0, 1'b1, 4'd3, 1'b0);
    check("b3_pin", int'(PIN), 4'b1010);

    run_cmd("b2_ch0_release", 2'd0, 1'b0, 4'd2, 1'b0);
    check("b2_pin", int'(PIN), 4'b1011);

    // Pin 2 is already low; a press must still bounce it high and back.
    run_cmd("same_level_ch2", 2'd2, 1'b1, 4'd1, 1'b0);
    check("same_pin", int'(PIN), 4'b1011);

    run_cmd("spam_ch1", 2'd1, 1'b1, 4'd2, 1'b1);
    @(posedge CLK); #1;
    check("spam_not_taken_busy", int'(busy), 0);
    check("spam_pin3", int'(PIN[3]), 1);
    check("spam_pin", int'(PIN), 4'b1001);

    // Abort inside GLITCH_OFF on channel 3.
    cmd_valid = 1'b1; cmd_chan = 2'd3; cmd_press = 1'b1; cmd_bounces = 4'd15;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (busy && PIN[3]) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reached_off", int'(hit), 1);
    #3;
    RST_N = 1'b0;
    #1;
    check("abort_pin", int'(PIN), 4'hF);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(cmd_ready), 0);
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      if (done) hit = 1'b1;
    end
    check("abort_no_done", int'(hit), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("abort_no_done_after", int'(done), 0);
    run_cmd("post_abort_ch1", 2'd1, 1'b1, 4'd1, 1'b0);
    check("post_abort_pin", int'(PIN), 4'b1101);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
